// File: rtl/sd_fifo_pkg.sv
// Shared constants for the SD data byte buffer: PHY addresses, default depth,
// and the status-bit positions used in fifo_full/fifo_empty.
package sd_fifo_pkg;

  localparam int         SD_DEPTH_LOG2 = 4;
  localparam logic [1:0] SD_ADR_TX     = 2'd2;
  localparam logic [1:0] SD_ADR_RX     = 2'd3;

  localparam int IDX_TX = 0;
  localparam int IDX_RX = 1;

endpackage

// File: rtl/sd_byte_fifo.sv
// Purpose: one synchronous byte FIFO, DEPTH_LOG2+1 bit pointers, registered dout.
// Latency: popped byte on dout one cycle after the pop edge; flags follow the pointers.
// Backpressure: push when full and pop when empty are ignored; SD_FIFO_LEVEL_EN adds level.
module sd_byte_fifo
  import sd_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = SD_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic [7:0]          din,
  input  logic                pop,
  output logic [7:0]          dout,
  output logic                full,
  output logic                empty
`ifdef SD_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] occ;
  logic                push_ok;
  logic                pop_ok;

  // Flags come from the registered pointers, so full/empty seen here are the
  // pre-edge state: a push into empty and a pop from full are judged before either moves.
  assign occ     = wr_ptr - rd_ptr;
  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

`ifdef SD_FIFO_LEVEL_EN
  assign level = occ;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        dout   <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sd_data_fifo.sv
// Purpose: host<->SD PHY byte buffering (TX host->PHY, RX PHY->host) with sticky errors.
// Latency: 1 cycle strobe-to-data on both sides; backpressure via fifo_full/fifo_empty, over/underruns dropped.
// Optional macro SD_FIFO_LEVEL_EN exposes tx_level/rx_level occupancy outputs.
module sd_data_fifo
  import sd_fifo_pkg::*;
#(
  parameter int         DEPTH_LOG2 = SD_DEPTH_LOG2,
  parameter logic [1:0] TX_ADR     = SD_ADR_TX,
  parameter logic [1:0] RX_ADR     = SD_ADR_RX
) (
  input  logic                sd_clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                host_wr_en,
  input  logic [7:0]          host_wr_data,
  input  logic                host_rd_en,
  output logic [7:0]          host_rd_data,
  output logic                host_rd_valid,
  input  logic [1:0]          sd_adr_i,
  input  logic                sd_re_i,
  input  logic                sd_we_i,
  input  logic [7:0]          sd_dat_i,
  output logic [7:0]          sd_dat_o,
  output logic [1:0]          fifo_full,
  output logic [1:0]          fifo_empty,
  output logic                tx_underflow,
  output logic                rx_overflow
`ifdef SD_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic [DEPTH_LOG2:0] rx_level
`endif
);

  logic tx_pop;
  logic rx_push;
  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;

  // PHY strobes only count when they carry the matching FIFO address.
  assign tx_pop  = sd_re_i && (sd_adr_i == TX_ADR);
  assign rx_push = sd_we_i && (sd_adr_i == RX_ADR);

  assign fifo_full[IDX_TX]  = tx_full;
  assign fifo_full[IDX_RX]  = rx_full;
  assign fifo_empty[IDX_TX] = tx_empty;
  assign fifo_empty[IDX_RX] = rx_empty;

  sd_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (sd_clk),
    .rst   (rst),
    .flush (flush),
    .push  (host_wr_en),
    .din   (host_wr_data),
    .pop   (tx_pop),
    .dout  (sd_dat_o),
    .full  (tx_full),
    .empty (tx_empty)
`ifdef SD_FIFO_LEVEL_EN
    ,
    .level (tx_level)
`endif
  );

  sd_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (sd_clk),
    .rst   (rst),
    .flush (flush),
    .push  (rx_push),
    .din   (sd_dat_i),
    .pop   (host_rd_en),
    .dout  (host_rd_data),
    .full  (rx_full),
    .empty (rx_empty)
`ifdef SD_FIFO_LEVEL_EN
    ,
    .level (rx_level)
`endif
  );

  always_ff @(posedge sd_clk) begin
    if (rst || flush) begin
      host_rd_valid <= 1'b0;
    end else begin
      host_rd_valid <= host_rd_en && !rx_empty;
    end
  end

  // Sticky until rst/flush so firmware can inspect them after the block completes.
  always_ff @(posedge sd_clk) begin
    if (rst || flush) begin
      tx_underflow <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      if (tx_pop && tx_empty) begin
        tx_underflow <= 1'b1;
      end
      if (rx_push && rx_full) begin
        rx_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_data_fifo.sv
// Bench for sd_data_fifo: queue models for TX and RX, one task per scenario.
module tb_sd_data_fifo;

  logic       sd_clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       host_wr_en;
  logic [7:0] host_wr_data;
  logic       host_rd_en;
  logic [7:0] host_rd_data;
  logic       host_rd_valid;
  logic [1:0] sd_adr_i;
  logic       sd_re_i;
  logic       sd_we_i;
  logic [7:0] sd_dat_i;
  logic [7:0] sd_dat_o;
  logic [1:0] fifo_full;
  logic [1:0] fifo_empty;
  logic       tx_underflow;
  logic       rx_overflow;
`ifdef SD_FIFO_LEVEL_EN
  logic [4:0] tx_level;
  logic [4:0] rx_level;
`endif

  int checks = 0;
  int passes = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_tx;

  always #5 sd_clk = ~sd_clk;

  sd_data_fifo dut (
    .sd_clk        (sd_clk),
    .rst           (rst),
    .flush         (flush),
    .host_wr_en    (host_wr_en),
    .host_wr_data  (host_wr_data),
    .host_rd_en    (host_rd_en),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .sd_adr_i      (sd_adr_i),
    .sd_re_i       (sd_re_i),
    .sd_we_i       (sd_we_i),
    .sd_dat_i      (sd_dat_i),
    .sd_dat_o      (sd_dat_o),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .tx_underflow  (tx_underflow),
    .rx_overflow   (rx_overflow)
`ifdef SD_FIFO_LEVEL_EN
    ,
    .tx_level      (tx_level),
    .rx_level      (rx_level)
`endif
  );

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (fifo_empty !== 2'b11) $display("FAIL reset_empty got=%b exp=11", fifo_empty); else passes++;
    checks++; if (fifo_full !== 2'b00) $display("FAIL reset_full got=%b exp=00", fifo_full); else passes++;
    checks++; if (sd_dat_o !== 8'h00) $display("FAIL reset_sd_dat_o got=%h exp=00", sd_dat_o); else passes++;
    checks++; if (host_rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", host_rd_data); else passes++;
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", host_rd_valid); else passes++;
    checks++; if (tx_underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", tx_underflow); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", rx_overflow); else passes++;
  endtask

  task automatic test_tx_fill();
    logic [7:0] exp;
    for (int i = 0; i < 17; i++) begin
      host_wr_en   = 1'b1;
      host_wr_data = (i < 16) ? 8'(8'h11 + i) : 8'hFF;
      if (tx_q.size() < 16) tx_q.push_back(host_wr_data);
      tick();
      if (i == 15) begin
        checks++; if (fifo_full[0] !== 1'b1) $display("FAIL tx_full got=%b exp=1", fifo_full[0]); else passes++;
      end
    end
    host_wr_en = 1'b0;
    sd_adr_i   = 2'd2;
    sd_re_i    = 1'b1;
    exp        = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (tx_q.size() > 0) exp = tx_q.pop_front();
      tick();
      checks++; if (sd_dat_o !== exp) $display("FAIL tx_order[%0d] got=%h exp=%h", i, sd_dat_o, exp); else passes++;
    end
    sd_re_i = 1'b0;
    last_tx = exp;
    checks++; if (fifo_empty[0] !== 1'b1) $display("FAIL tx_drained_empty got=%b exp=1", fifo_empty[0]); else passes++;
    checks++; if (fifo_full[0] !== 1'b0) $display("FAIL tx_drained_full got=%b exp=0", fifo_full[0]); else passes++;
  endtask

  task automatic test_underflow();
    sd_adr_i = 2'd2;
    sd_re_i  = 1'b1;
    tick();
    sd_re_i = 1'b0;
    checks++; if (sd_dat_o !== last_tx) $display("FAIL underflow_hold got=%h exp=%h", sd_dat_o, last_tx); else passes++;
    checks++; if (tx_underflow !== 1'b1) $display("FAIL underflow_set got=%b exp=1", tx_underflow); else passes++;
    repeat (3) tick();
    checks++; if (tx_underflow !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", tx_underflow); else passes++;
    checks++; if (fifo_empty[0] !== 1'b1) $display("FAIL underflow_empty got=%b exp=1", fifo_empty[0]); else passes++;
  endtask

  task automatic test_rx_single();
    logic [7:0] exp;
    sd_adr_i = 2'd3;
    sd_we_i  = 1'b1;
    sd_dat_i = 8'hA5;
    rx_q.push_back(sd_dat_i);
    tick();
    sd_we_i = 1'b0;
    checks++; if (fifo_empty[1] !== 1'b0) $display("FAIL rx_not_empty got=%b exp=0", fifo_empty[1]); else passes++;
    exp = rx_q.pop_front();
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
    checks++; if (host_rd_valid !== 1'b1) $display("FAIL rx_valid got=%b exp=1", host_rd_valid); else passes++;
    checks++; if (host_rd_data !== exp) $display("FAIL rx_data got=%h exp=%h", host_rd_data, exp); else passes++;
    tick();
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL rx_valid_drop got=%b exp=0", host_rd_valid); else passes++;
    checks++; if (host_rd_data !== exp) $display("FAIL rx_data_hold got=%h exp=%h", host_rd_data, exp); else passes++;
    checks++; if (fifo_empty[1] !== 1'b1) $display("FAIL rx_empty_again got=%b exp=1", fifo_empty[1]); else passes++;
  endtask

  task automatic test_rx_overflow();
    logic [7:0] exp;
    sd_adr_i = 2'd3;
    sd_we_i  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sd_dat_i = 8'(8'h30 + i);
      if (rx_q.size() < 16) rx_q.push_back(sd_dat_i);
      tick();
    end
    checks++; if (fifo_full[1] !== 1'b1) $display("FAIL rx_full got=%b exp=1", fifo_full[1]); else passes++;
    // push 0x5A and pop in the same cycle while full
    sd_dat_i   = 8'h5A;
    host_rd_en = 1'b1;
    if (rx_q.size() < 16) rx_q.push_back(sd_dat_i);
    exp = rx_q.pop_front();
    tick();
    sd_we_i    = 1'b0;
    host_rd_en = 1'b0;
    checks++; if (host_rd_valid !== 1'b1) $display("FAIL ovf_pop_valid got=%b exp=1", host_rd_valid); else passes++;
    checks++; if (host_rd_data !== exp) $display("FAIL ovf_pop_data got=%h exp=%h", host_rd_data, exp); else passes++;
    checks++; if (rx_overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", rx_overflow); else passes++;
    checks++; if (fifo_full[1] !== 1'b0) $display("FAIL ovf_not_full got=%b exp=0", fifo_full[1]); else passes++;
    sd_adr_i = 2'd1;
    sd_we_i  = 1'b1;
    sd_dat_i = 8'h77;
    tick();
    sd_we_i = 1'b0;
    checks++; if (fifo_full[1] !== 1'b0) $display("FAIL adr1_ignored got=%b exp=0", fifo_full[1]); else passes++;
    host_rd_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      tick();
      checks++; if (host_rd_data !== exp) $display("FAIL rx_drain[%0d] got=%h exp=%h", i, host_rd_data, exp); else passes++;
    end
    host_rd_en = 1'b0;
    checks++; if (fifo_empty[1] !== 1'b1) $display("FAIL rx_drain_empty got=%b exp=1", fifo_empty[1]); else passes++;
    tick();
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL rx_drain_valid got=%b exp=0", host_rd_valid); else passes++;
  endtask

  task automatic test_tx_wrap_flush();
    logic [7:0] exp;
    logic       pop_acc;
    logic       push_acc;
    int         k;
    k = 0;
    sd_adr_i = 2'd2;
    while (tx_q.size() < 8) begin
      host_wr_en   = 1'b1;
      host_wr_data = 8'(k) ^ 8'h5A;
      tx_q.push_back(host_wr_data);
      k++;
      tick();
    end
    while (k < 300) begin
      host_wr_en   = 1'b1;
      host_wr_data = 8'(k) ^ 8'h5A;
      sd_re_i      = 1'b1;
      pop_acc      = (tx_q.size() > 0);
      push_acc     = (tx_q.size() < 16);
      if (pop_acc) exp = tx_q.pop_front();
      if (push_acc) tx_q.push_back(host_wr_data);
      k++;
      tick();
      if (pop_acc) begin
        checks++; if (sd_dat_o !== exp) $display("FAIL tx_wrap[%0d] got=%h exp=%h", k, sd_dat_o, exp); else passes++;
        last_tx = exp;
      end
    end
    // flush with push and pop also asserted: flush wins
    flush        = 1'b1;
    host_wr_data = 8'hEE;
    tx_q.delete();
    tick();
    flush      = 1'b0;
    host_wr_en = 1'b0;
    sd_re_i    = 1'b0;
    checks++; if (fifo_empty !== 2'b11) $display("FAIL flush_empty got=%b exp=11", fifo_empty); else passes++;
    checks++; if (fifo_full !== 2'b00) $display("FAIL flush_full got=%b exp=00", fifo_full); else passes++;
    checks++; if (tx_underflow !== 1'b0) $display("FAIL flush_underflow got=%b exp=0", tx_underflow); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL flush_overflow got=%b exp=0", rx_overflow); else passes++;
    checks++; if (sd_dat_o !== last_tx) $display("FAIL flush_dat_hold got=%h exp=%h", sd_dat_o, last_tx); else passes++;
  endtask

  task automatic test_simul_empty();
    host_wr_en   = 1'b1;
    host_wr_data = 8'hC3;
    sd_adr_i     = 2'd2;
    sd_re_i      = 1'b1;
    tx_q.push_back(host_wr_data);
    tick();
    host_wr_en = 1'b0;
    sd_re_i    = 1'b0;
    checks++; if (sd_dat_o !== last_tx) $display("FAIL simul_dat_hold got=%h exp=%h", sd_dat_o, last_tx); else passes++;
    checks++; if (tx_underflow !== 1'b1) $display("FAIL simul_underflow got=%b exp=1", tx_underflow); else passes++;
    checks++; if (fifo_empty[0] !== 1'b0) $display("FAIL simul_occ1 got=%b exp=0", fifo_empty[0]); else passes++;
    sd_re_i = 1'b1;
    last_tx = tx_q.pop_front();
    tick();
    sd_re_i = 1'b0;
    checks++; if (sd_dat_o !== last_tx) $display("FAIL simul_pop got=%h exp=%h", sd_dat_o, last_tx); else passes++;
    checks++; if (fifo_empty[0] !== 1'b1) $display("FAIL simul_empty got=%b exp=1", fifo_empty[0]); else passes++;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    host_wr_en   = 1'b0;
    host_wr_data = 8'h00;
    host_rd_en   = 1'b0;
    sd_adr_i     = 2'd0;
    sd_re_i      = 1'b0;
    sd_we_i      = 1'b0;
    sd_dat_i     = 8'h00;
    last_tx      = 8'h00;
    test_reset();
    test_tx_fill();
    test_underflow();
    test_rx_single();
    test_rx_overflow();
    test_tx_wrap_flush();
    test_simul_empty();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sd_data_fifo.md
Name: sd_data_fifo

Overview:
- Byte buffering stage between the host data bus and the SD 4-bit data PHY.
- Holds two independent byte FIFOs:
  - TX: host pushes, PHY pops when it presents address 2 with a read strobe.
  - RX: PHY pushes when it presents address 3 with a write strobe; host pops.
- Supplies full/empty status to both sides, plus sticky error flags for underflow/overflow during a block transfer.

Parameters:
- DEPTH_LOG2, 4, log2 of the byte depth of each FIFO (default 16 entries).
- TX_ADR, 2, PHY address selecting the TX FIFO.
- RX_ADR, 3, PHY address selecting the RX FIFO.

Ports:
- sd_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  sync clear of both FIFOs and error flags.
- host_wr_en  in  1  push host_wr_data into TX.
- host_wr_data  in  8  TX byte from host.
- host_rd_en  in  1  pop RX.
- host_rd_data  out  8  RX byte, registered.
- host_rd_valid  out  1  host_rd_data valid this cycle.
- sd_adr_i  in  2  PHY FIFO select.
- sd_re_i  in  1  PHY read strobe (TX pop).
- sd_we_i  in  1  PHY write strobe (RX push).
- sd_dat_i  in  8  RX byte from PHY.
- sd_dat_o  out  8  TX byte to PHY, registered.
- fifo_full  out  2  bit0 = TX full, bit1 = RX full.
- fifo_empty  out  2  bit0 = TX empty, bit1 = RX empty.
- tx_underflow  out  1  sticky: PHY read from empty TX.
- rx_overflow  out  1  sticky: PHY write to full RX.

Behaviour:
- Reset (rst=1 at rising edge):
  - Pointers zeroed.
  - host_rd_data=0, host_rd_valid=0, sd_dat_o=0.
  - fifo_full=2'b00, fifo_empty=2'b11.
  - Both error flags 0.
- flush: same effect as reset, but pointers only. Takes priority over every simultaneous push/pop.
- Storage: pointers DEPTH_LOG2+1 bits wide.
  - Occupancy = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
  - full when occupancy == 2^DEPTH_LOG2; empty when occupancy == 0.
  - Pointer wrap-around is natural binary roll-over.
- TX push: host_wr_en && !fifo_full[0] → write at wr_ptr, increment. Push while full is dropped silently.
- TX pop: sd_re_i && sd_adr_i==TX_ADR && !fifo_empty[0] → sd_dat_o <= mem[rd_ptr], rd_ptr++.
  - Latency: data appears at sd_dat_o one cycle after the strobe edge and holds until the next pop.
  - Pop while empty: sd_dat_o holds its old value, no pointer move, tx_underflow <= 1.
- RX push: sd_we_i && sd_adr_i==RX_ADR && !fifo_full[1] → store sd_dat_i.
  - Push while full: byte dropped, rx_overflow <= 1.
  - The CRC status token the PHY writes after a write block is an ordinary RX push.
- RX pop: host_rd_en && !fifo_empty[1] → host_rd_data <= mem, host_rd_valid=1 next cycle. Otherwise host_rd_valid=0 and host_rd_data holds.
- Strobes carrying any other address are ignored.
- Simultaneous push and pop on the same FIFO are both honoured.
  - Empty + push + pop: the pop is rejected (empty is sampled before the push), the push is accepted; result occupancy 1.
  - Full + push + pop: the pop is accepted, the push is rejected (full sampled); result occupancy DEPTH-1.
- Flags are combinational from pointers (registered pointers), so they update the cycle after the causing edge.
- Error flags clear only on rst or flush.

Optional Feature:
- Macro: SD_FIFO_LEVEL_EN.
- Defined: adds output ports tx_level and rx_level, each DEPTH_LOG2+1 bits, equal to current occupancy and updated with the pointers.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sd_fifo_pkg:
  - Address constants SD_ADR_TX=2 and SD_ADR_RX=3.
  - Default DEPTH_LOG2.
  - fifo_full/fifo_empty bit-index constants (IDX_TX=0, IDX_RX=1).
- Sub-module sd_byte_fifo: one parameterised synchronous FIFO with push, pop, din, registered dout, full, empty and optional level. Instantiated twice.
- Top-level holds the address decode, strobe qualification and sticky error flags.

Test Plan:
- Reset release → fifo_empty=2'b11, fifo_full=2'b00, sd_dat_o=0, host_rd_valid=0, both error flags 0.
- Host pushes 0x11..0x20 (16 bytes) → fifo_full[0]=1; a 17th push of 0xFF is dropped; 16 PHY reads at adr 2 return 0x11..0x20 in order, each one cycle after the strobe; then fifo_empty[0]=1.
- PHY read at adr 2 with TX empty → sd_dat_o unchanged, tx_underflow=1 and it stays 1 until flush.
- PHY writes 0xA5 to adr 3, then host_rd_en → host_rd_data=0xA5, host_rd_valid=1 for one cycle; fifo_empty[1] returns to 1.
- Fill RX with 16 bytes, then push 0x5A at adr 3 while the host pops in the same cycle → pop accepted, 0x5A dropped, rx_overflow=1; a PHY write at adr 1 has no effect.
- Write 300 bytes through TX with interleaved push/pop at occupancy 8 → pointers wrap correctly, data order preserved. flush mid-stream → empty=2'b11 next cycle and error flags cleared.
